// File: rtl/frame_sequencer.sv
// frame_sequencer: buffers a non-stallable sample stream in a circular RAM and
// replays overlapping N-sample frames, advancing HOP samples per frame, as
// contiguous one-sample-per-cycle bursts to the window stage.
// Optional build macro FRAME_SEQ_COUNT_EN adds frame_count and occ_level outputs.
//
// state | meaning
// IDLE  | waiting for occ >= N and frame_ready
// SEND  | issuing one RAM read per cycle for idx = 0..N-1
module frame_sequencer #(
    parameter int Q_IN   = 15,
    parameter int N      = 256,
    parameter int HOP    = 128,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_valid,
    input  logic signed [Q_IN:0]   sample_in,
    input  logic                   frame_ready,
    output logic                   valid_out,
    output logic signed [Q_IN:0]   data_out,
    output logic                   frame_start,
    output logic                   frame_end,
    output logic                   busy,
    output logic                   overrun
`ifdef FRAME_SEQ_COUNT_EN
    ,
    output logic [15:0]            frame_count,
    output logic [ADDR_W:0]        occ_level
`endif
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   N_C      = (ADDR_W+1)'(N);
    localparam logic [ADDR_W:0]   HOP_C    = (ADDR_W+1)'(HOP);
    localparam logic [ADDR_W-1:0] HOP_A    = ADDR_W'(HOP);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

    state_t                state;
    logic [ADDR_W-1:0]     base;
    logic [ADDR_W-1:0]     idx;
    logic [ADDR_W:0]       occ;
    logic                  wr_acc;
    logic                  retire;
    logic [ADDR_W-1:0]     wr_addr;
    logic [ADDR_W-1:0]     rd_addr;
    logic signed [Q_IN:0]  mem [DEPTH];

    // occ < DEPTH guarantees occ[ADDR_W-1:0] is the true offset, so the add wraps mod DEPTH
    assign wr_acc  = sample_valid && (occ < DEPTH_C);
    assign wr_addr = base + occ[ADDR_W-1:0];
    assign rd_addr = base + idx;
    assign retire  = (state == SEND) && (idx == LAST_IDX);

    // Sample RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_addr] <= sample_in;
        end
    end

    // Sticky flag for a sample arriving while the buffer is full
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (sample_valid && !wr_acc) begin
            overrun <= 1'b1;
        end
    end

    // Frame scheduler: occupancy, frame base pointer, read index and busy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            base  <= '0;
            idx   <= '0;
            occ   <= '0;
            busy  <= 1'b0;
        end else begin
            // retire and write on the same edge fold into one occupancy update
            if (retire) begin
                occ <= occ - HOP_C + (ADDR_W+1)'(wr_acc);
            end else begin
                occ <= occ + (ADDR_W+1)'(wr_acc);
            end
            case (state)
                IDLE: begin
                    if (occ >= N_C && frame_ready) begin
                        state <= SEND;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SEND: begin
                    if (retire) begin
                        base  <= base + HOP_A;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read data stage: RAM output and frame markers land one cycle after issue
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            data_out    <= '0;
        end else begin
            valid_out   <= (state == SEND);
            frame_start <= (state == SEND) && (idx == '0);
            frame_end   <= retire;
            if (state == SEND) begin
                data_out <= mem[rd_addr];
            end
        end
    end

`ifdef FRAME_SEQ_COUNT_EN
    assign occ_level = occ;

    // Completed-frame counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_count <= '0;
        end else if (frame_end) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed and randomized stimulus for frame_sequencer,
// checked against a queue-based reference of the sample stream.
module tb_frame_sequencer;

    localparam int N     = 256;
    localparam int HOP   = 128;
    localparam int DEPTH = 512;
    localparam int AW    = 9;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               sample_valid = 1'b0;
    logic signed [15:0] sample_in = '0;
    logic               frame_ready = 1'b0;
    logic               valid_out;
    logic signed [15:0] data_out;
    logic               frame_start;
    logic               frame_end;
    logic               busy;
    logic               overrun;
`ifdef FRAME_SEQ_COUNT_EN
    logic [15:0]        frame_count;
    logic [AW:0]        occ_level;
`endif

    frame_sequencer #(
        .Q_IN(15), .N(N), .HOP(HOP), .DEPTH(DEPTH), .ADDR_W(AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .frame_ready  (frame_ready),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .busy         (busy),
        .overrun      (overrun)
`ifdef FRAME_SEQ_COUNT_EN
        ,
        .frame_count  (frame_count),
        .occ_level    (occ_level)
`endif
    );

    always #5 clk = ~clk;

    // Reference: q holds every accepted, not yet retired sample, oldest first.
    // Its size is the occupancy; frame k replays q[0..N-1] and retires HOP.
    logic [15:0] q[$];
    int          checks = 0;
    int          errors = 0;
    int          pos = 0;
    int          nfs = 0;
    int          nfe = 0;
    int          fc_model = 0;
    int          brun = 0;
    int          cyc = 0;
    int          first_fs_cyc = -1;
    logic        m_ovr = 1'b0;
    logic        r1 = 1'b0;
    logic        prev_fe = 1'b0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pos          = 0;
        brun         = 0;
        r1           = 1'b0;
        prev_fe      = 1'b0;
        m_ovr        = 1'b0;
        fc_model     = 0;
        first_fs_cyc = -1;
    endtask

    // Called at the falling edge: accounts for the rising edge just passed
    task automatic observe();
        cyc++;
        if (sample_valid) begin
            if (q.size() < DEPTH) q.push_back(sample_in);
            else m_ovr = 1'b1;
        end
`ifdef FRAME_SEQ_COUNT_EN
        chk_val("frame_count", {16'd0, frame_count}, fc_model);
`endif
        if (valid_out) begin
            if (pos == 0) begin
                nfs++;
                if (first_fs_cyc < 0) first_fs_cyc = cyc;
                chk_val("start_ready", {31'd0, r1}, 1);
                chk_val("start_gap", {31'd0, prev_fe}, 0);
                chk_val("start_occ", {31'd0, q.size() >= N}, 1);
            end
            if (pos < q.size()) chk_val("data", {16'd0, data_out}, {16'd0, q[pos]});
            else chk_val("data_avail", 0, 1);
            chk_val("frame_start", {31'd0, frame_start}, {31'd0, pos == 0});
            chk_val("frame_end", {31'd0, frame_end}, {31'd0, pos == N - 1});
            if (pos == N - 1) begin
                repeat (HOP) void'(q.pop_front());
                pos = 0;
                nfe++;
                fc_model = (fc_model + 1) % 65536;
            end else begin
                pos++;
            end
        end else begin
            chk_val("idle_markers", {30'd0, frame_start, frame_end}, 0);
        end
        prev_fe = frame_end;
        if (busy) begin
            brun++;
        end else begin
            if (brun != 0) chk_val("busy_len", brun, N);
            brun = 0;
        end
        chk_val("overrun", {31'd0, overrun}, {31'd0, m_ovr});
`ifdef FRAME_SEQ_COUNT_EN
        chk_val("occ_level", {22'd0, occ_level}, q.size());
`endif
        r1 = frame_ready;
    endtask

    task automatic cyc_drive(input logic v, input logic [15:0] d, input logic r);
        sample_valid = v;
        sample_in    = d;
        frame_ready  = r;
        @(posedge clk);
        @(negedge clk);
        observe();
    endtask

    // Asserts reset asynchronously; outputs must clear without waiting for a clock
    task automatic apply_reset();
        reset        = 1'b0;
        sample_valid = 1'b0;
        frame_ready  = 1'b0;
        #1;
        chk_val("rst_valid", {31'd0, valid_out}, 0);
        chk_val("rst_fend", {31'd0, frame_end}, 0);
        chk_val("rst_fstart", {31'd0, frame_start}, 0);
        chk_val("rst_busy", {31'd0, busy}, 0);
        chk_val("rst_ovr", {31'd0, overrun}, 0);
        chk_val("rst_data", {16'd0, data_out}, 0);
        repeat (2) @(negedge clk);
        model_reset();
        reset = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (n < 2000 && !(q.size() < N && !busy && !valid_out && pos == 0)) begin
            cyc_drive(1'b0, 16'd0, 1'b1);
            n++;
        end
        repeat (3) cyc_drive(1'b0, 16'd0, 1'b1);
        chk_val(tag, {31'd0, q.size() < N && !busy && !valid_out}, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int nfe0;
        int nfs0;
        int w_last;
        int n;
        logic v;
        logic r;

        // Ramp 0..383 with frame_ready high: frames 0..255 then 128..383
        apply_reset();
        nfe0 = nfe;
        w_last = 0;
        for (int i = 0; i < 384; i++) begin
            cyc_drive(1'b1, 16'(i), 1'b1);
            if (i == N - 1) w_last = cyc;
        end
        chk_val("first_lat", first_fs_cyc - w_last, 2);
        drain("p1_drain");
        chk_val("p1_frames", nfe - nfe0, 2);
        chk_val("p1_occ", q.size(), 128);

        // Fill to DEPTH with frame_ready low; the next sample overflows
        apply_reset();
        for (int i = 0; i < DEPTH; i++) cyc_drive(1'b1, 16'(i), 1'b0);
        chk_val("p2_full_no_ovr", {31'd0, overrun}, 0);
        cyc_drive(1'b1, 16'd512, 1'b0);
        chk_val("p2_ovr", {31'd0, overrun}, 1);
        nfe0 = nfe;
        drain("p2_drain");
        chk_val("p2_frames", nfe - nfe0, 3);
        chk_val("p2_ovr_sticky", {31'd0, overrun}, 1);

        // Continuous samples while sending
        apply_reset();
        nfe0 = nfe;
        for (int i = 0; i < 700; i++) cyc_drive(1'b1, 16'(i), 1'b1);
        drain("p3_drain");
        chk_val("p3_frames_min", {31'd0, (nfe - nfe0) >= 3}, 1);

        // Reset in the middle of a burst, then require a full refill
        apply_reset();
        for (int i = 0; i < N; i++) cyc_drive(1'b1, 16'(i + 7), 1'b1);
        n = 0;
        while (pos != 100 && n < 500) begin
            cyc_drive(1'b0, 16'd0, 1'b1);
            n++;
        end
        chk_val("p4_reach_idx", pos, 100);
        apply_reset();
        nfs0 = nfs;
        nfe0 = nfe;
        for (int i = 0; i < N - 1; i++) cyc_drive(1'b1, 16'(1000 + i), 1'b1);
        repeat (5) cyc_drive(1'b0, 16'd0, 1'b1);
        chk_val("p4_no_early", nfs - nfs0, 0);
        cyc_drive(1'b1, 16'd2000, 1'b1);
        drain("p4_drain");
        chk_val("p4_frame", nfe - nfe0, 1);

        // Randomized traffic with long frame_ready stalls to reach overflow
        apply_reset();
        r = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ((i % 300) == 0) r = ($urandom_range(0, 2) != 0);
            v = ($urandom_range(0, 3) != 0);
            cyc_drive(v, 16'($urandom), r && ($urandom_range(0, 9) != 0));
        end
        drain("p5_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
